systolic_tile_engine: RTL and testbench
=======================================

Name: systolic_tile_engine

Overview:
Next-generation output-stationary systolic GEMM tile: computes C[ROWS][COLS] = sum over k of a_k (column of A) times b_k (row of B), for a runtime depth k_len.
- Generalises the square, free-running array to rectangular ROWS x COLS.
- Adds internal input skewing, valid/ready streaming in and out, a tile-level FSM, saturating accumulation with a sticky flag, and row-serial result drain.
- Sits between the operand buffers and the writeback path in the accelerator datapath.

Parameters:
ROWS, 4, PE rows; length of the A vector per beat.
COLS, 4, PE columns; length of the B vector per beat.
DATA_WIDTH, 8, signed operand width.
ACC_WIDTH, 32, signed accumulator width; must be >= 2*DATA_WIDTH.
K_MAX, 256, maximum accumulation depth.

Ports:
clk  in  1  clock.
reset  in  1  synchronous active-high reset.
start  in  1  begin a tile; sampled only in IDLE.
k_len  in  $clog2(K_MAX+1)  beats in this tile; sampled with start.
in_valid  in  1  operand beat valid.
in_ready  out  1  beat accepted when in_valid & in_ready.
a_vec  in  ROWS*DATA_WIDTH  signed; row i at bits [i*DATA_WIDTH +: DATA_WIDTH].
b_vec  in  COLS*DATA_WIDTH  signed; column j at bits [j*DATA_WIDTH +: DATA_WIDTH].
out_valid  out  1  result row valid.
out_ready  in  1  result row consumed when out_valid & out_ready.
out_row  out  COLS*ACC_WIDTH  accumulators of row out_row_idx; column j at bits [j*ACC_WIDTH +: ACC_WIDTH].
out_row_idx  out  $clog2(ROWS) (min 1)  row index of out_row.
busy  out  1  state != IDLE.
sat_flag  out  1  sticky: any PE clamped during the current tile.

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset.
- Reset effect: state = IDLE; all PE accumulators, skew registers, PE pipeline registers and counters cleared to 0. in_ready = 0, out_valid = 0, busy = 0, sat_flag = 0, out_row = 0, out_row_idx = 0.
- Reset mid-operation: reset asserted in any state aborts the tile with the same effect; no partial output is emitted.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
- IDLE:
  - start = 1 clears accumulators and sat_flag and latches k_len.
  - Next state is LOAD if k_len > 0, else DRAIN, which outputs all-zero rows.
- LOAD:
  - in_ready = 1.
  - The array (skew registers, PE pipeline and MACs) advances only on an accepted beat. Cycles with in_valid = 0 freeze the whole array, so bubbles cost nothing.
  - After k_len accepted beats: go to FLUSH, or to DRAIN if ROWS+COLS-2 == 0.
- Skew:
  - a_vec row i is delayed i advances; b_vec column j is delayed j advances.
  - a moves right, b moves down, one PE per advance.
  - Beat k contributes a_k[i]*b_k[j] to PE(i,j) on the (i+j)-th advance after the advance that accepted it, counting that advance as the 0th.
- FLUSH:
  - The array advances every cycle with zero operands injected.
  - Lasts exactly ROWS+COLS-2 cycles, then go to DRAIN.
- DRAIN:
  - out_valid = 1; out_row and out_row_idx = r, starting at r = 0.
  - Data stays stable while out_valid & !out_ready.
  - On handshake r increments. The handshake on r = ROWS-1 returns to IDLE, with out_valid = 0 in the next cycle.
  - Accumulators hold their values until the next start.
- Arithmetic:
  - Product is the signed 2*DATA_WIDTH product, sign-extended.
  - Sum is computed at ACC_WIDTH+1 bits, then clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Any clamp sets sat_flag, which holds until the next start or reset.
- Ignored inputs: start outside IDLE; in_valid outside LOAD; out_ready outside DRAIN.
- Same-cycle events: start and reset together, reset wins. The last beat is accepted and the state changes in the same cycle, with no extra bubble.
- Latency: last beat accepted at cycle T; the first out_valid is at cycle T + ROWS+COLS-1.

Test Plan:
- ROWS=COLS=4, k_len=4. A = identity, B rows = {1..4},{5..8},{9..12},{13..16}, in_valid held high. Rows out = B rows, in order, idx 0..3. First out_valid 7 cycles after the last beat. sat_flag = 0.
- ROWS=2, COLS=3, k_len=3. Beats a=(-5,3), b=(4,-3,2), repeated 3 times. Row0 = (-60,45,-30), row1 = (36,-27,18).
- Bubbles and backpressure: the first test with in_valid toggling 1,0,0,1,... and out_ready low for 3 cycles per row. Results are identical; out_row is stable while stalled; exactly 4 output handshakes.
- ACC_WIDTH=16, k_len=3, all operands 127. Every PE outputs 32767 (two beats give 32258, the third clamps) and sat_flag = 1. The same test with all a = -128 and b = 127 gives -32768.
- Reset after 2 of 4 beats accepted: busy = 0 and in_ready = 0 the next cycle, no out_valid. A new tile using the first test's data then gives exact results, with no residue.
- start pulsed during LOAD and DRAIN is ignored, and the results are unchanged. k_len = 0 gives 4 all-zero rows.

Source files
------------

// File: rtl/systolic_tile_engine.sv
// Output-stationary systolic GEMM tile: ROWS x COLS saturating MAC array with
// internal operand skew, valid/ready streaming input and row-serial result drain.
module systolic_tile_engine #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int K_MAX      = 256,
  localparam int KW        = $clog2(K_MAX + 1),
  localparam int IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [KW-1:0]              k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0] a_vec,
  input  logic [COLS*DATA_WIDTH-1:0] b_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COLS*ACC_WIDTH-1:0]  out_row,
  output logic [IDX_W-1:0]           out_row_idx,
  output logic                       busy,
  output logic                       sat_flag
);

  localparam int FLUSH_LEN = ROWS + COLS - 2;
  localparam int FW        = $clog2(ROWS + COLS);
  localparam int SW        = ACC_WIDTH + 1;
  localparam int CW        = (COLS > 1) ? COLS - 1 : 1;
  localparam int RW        = (ROWS > 1) ? ROWS - 1 : 1;
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  state_t               state, state_n;
  logic [KW-1:0]        k_reg, beat_cnt;
  logic [FW-1:0]        flush_cnt;
  logic [IDX_W-1:0]     row_cnt;
  logic                 clr, accept, adv, drain_hs;
  logic                 last_beat, last_flush, last_row, ovf_any;

  logic signed [DATA_WIDTH-1:0]   a_in   [ROWS];
  logic signed [DATA_WIDTH-1:0]   b_in   [COLS];
  logic signed [DATA_WIDTH-1:0]   a_left [ROWS];
  logic signed [DATA_WIDTH-1:0]   b_top  [COLS];
  logic signed [DATA_WIDTH-1:0]   a_opa  [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]   b_opa  [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0]   a_r    [ROWS][CW];
  logic signed [DATA_WIDTH-1:0]   b_r    [RW][COLS];
  logic signed [2*DATA_WIDTH-1:0] prod   [ROWS][COLS];
  logic signed [SW-1:0]           sum    [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]    acc    [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]    acc_n  [ROWS][COLS];

  assign clr        = (state == IDLE) && start;
  assign accept     = (state == LOAD) && in_valid;
  // The whole array, skew included, moves only on accepted beats or flush cycles.
  assign adv        = accept || (state == FLUSH);
  assign drain_hs   = (state == DRAIN) && out_ready;
  assign last_beat  = (beat_cnt == k_reg - KW'(1));
  assign last_flush = (flush_cnt == FW'(FLUSH_LEN - 1));
  assign last_row   = (row_cnt == IDX_W'(ROWS - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (k_len != '0) ? LOAD : DRAIN;
      LOAD:    if (in_valid && last_beat) state_n = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
      FLUSH:   if (last_flush) state_n = DRAIN;
      DRAIN:   if (out_ready && last_row) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready    = (state == LOAD);
  assign out_valid   = (state == DRAIN);
  assign busy        = (state != IDLE);
  assign out_row_idx = row_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      k_reg     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
      row_cnt   <= '0;
      sat_flag  <= 1'b0;
    end else begin
      state <= state_n;
      if (clr) begin
        k_reg     <= k_len;
        beat_cnt  <= '0;
        flush_cnt <= '0;
        row_cnt   <= '0;
        sat_flag  <= 1'b0;
      end else begin
        if (accept) beat_cnt <= beat_cnt + KW'(1);
        if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
        if (drain_hs) row_cnt <= last_row ? '0 : row_cnt + IDX_W'(1);
        if (adv && ovf_any) sat_flag <= 1'b1;
      end
    end
  end

  // Zero operands are injected once LOAD is over so the flush adds nothing.
  always_comb begin
    for (int unsigned i = 0; i < ROWS; i++)
      a_in[i] = (state == LOAD) ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    for (int unsigned j = 0; j < COLS; j++)
      b_in[j] = (state == LOAD) ? b_vec[j*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    if (i == 0) begin : g_direct
      assign a_left[i] = a_in[i];
    end else begin : g_sr
      logic signed [DATA_WIDTH-1:0] sr [i];
      always_ff @(posedge clk) begin
        if (reset || clr) begin
          for (int unsigned s = 0; s < i; s++) sr[s] <= '0;
        end else if (adv) begin
          sr[0] <= a_in[i];
          for (int unsigned s = 1; s < i; s++) sr[s] <= sr[s-1];
        end
      end
      assign a_left[i] = sr[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    if (j == 0) begin : g_direct
      assign b_top[j] = b_in[j];
    end else begin : g_sr
      logic signed [DATA_WIDTH-1:0] sr [j];
      always_ff @(posedge clk) begin
        if (reset || clr) begin
          for (int unsigned s = 0; s < j; s++) sr[s] <= '0;
        end else if (adv) begin
          sr[0] <= b_in[j];
          for (int unsigned s = 1; s < j; s++) sr[s] <= sr[s-1];
        end
      end
      assign b_top[j] = sr[j-1];
    end
  end

  always_comb begin
    ovf_any = 1'b0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      a_opa[i][0] = a_left[i];
      for (int unsigned j = 1; j < COLS; j++) a_opa[i][j] = a_r[i][j-1];
    end
    for (int unsigned j = 0; j < COLS; j++) begin
      b_opa[0][j] = b_top[j];
      for (int unsigned i = 1; i < ROWS; i++) b_opa[i][j] = b_r[i-1][j];
    end
    for (int unsigned i = 0; i < ROWS; i++) begin
      for (int unsigned j = 0; j < COLS; j++) begin
        prod[i][j] = a_opa[i][j] * b_opa[i][j];
        sum[i][j]  = SW'(acc[i][j]) + SW'(prod[i][j]);
        if (sum[i][j][SW-1] != sum[i][j][SW-2]) begin
          acc_n[i][j] = sum[i][j][SW-1] ? ACC_MIN : ACC_MAX;
          ovf_any     = 1'b1;
        end else begin
          acc_n[i][j] = sum[i][j][ACC_WIDTH-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      for (int unsigned i = 0; i < ROWS; i++)
        for (int unsigned j = 0; j < COLS; j++) acc[i][j] <= '0;
      for (int unsigned i = 0; i < ROWS; i++)
        for (int unsigned j = 0; j < CW; j++) a_r[i][j] <= '0;
      for (int unsigned i = 0; i < RW; i++)
        for (int unsigned j = 0; j < COLS; j++) b_r[i][j] <= '0;
    end else if (adv) begin
      for (int unsigned i = 0; i < ROWS; i++)
        for (int unsigned j = 0; j < COLS; j++) acc[i][j] <= acc_n[i][j];
      for (int unsigned i = 0; i < ROWS; i++)
        for (int unsigned j = 0; j + 1 < COLS; j++) a_r[i][j] <= a_opa[i][j];
      for (int unsigned i = 0; i + 1 < ROWS; i++)
        for (int unsigned j = 0; j < COLS; j++) b_r[i][j] <= b_opa[i][j];
    end
  end

  always_comb begin
    out_row = '0;
    for (int unsigned j = 0; j < COLS; j++)
      out_row[j*ACC_WIDTH +: ACC_WIDTH] = acc[row_cnt][j];
  end

endmodule

// File: tb/tb_systolic_tile_engine.sv
// Bench for systolic_tile_engine: three configurations share one stimulus path,
// expected rows come from a saturating reference model held in a scoreboard queue.
module tb_systolic_tile_engine;

  typedef struct packed {
    logic [1:0]       idx;
    logic [3:0][31:0] v;
  } row_t;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, out_ready;
  logic [8:0]  k_len;
  logic [31:0] a_vec, b_vec;
  int          sel = 0;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          A[8][4];
  int          B[8][4];
  row_t        sb[$];
  logic        exp_sat;

  logic ir_a, ov_a, busy_a, sat_a; logic [127:0] row_a; logic [1:0] idx_a;
  logic ir_b, ov_b, busy_b, sat_b; logic [95:0]  row_b; logic       idx_b;
  logic ir_c, ov_c, busy_c, sat_c; logic [63:0]  row_c; logic [1:0] idx_c;

  logic             obs_ir, obs_ov, obs_busy, obs_sat;
  logic [3:0][31:0] obs_row;
  logic [1:0]       obs_idx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  systolic_tile_engine u_a (
    .clk(clk), .reset(reset), .start(start && sel == 0), .k_len(k_len),
    .in_valid(in_valid && sel == 0), .in_ready(ir_a), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(ov_a), .out_ready(out_ready && sel == 0), .out_row(row_a),
    .out_row_idx(idx_a), .busy(busy_a), .sat_flag(sat_a));

  systolic_tile_engine #(.ROWS(2), .COLS(3)) u_b (
    .clk(clk), .reset(reset), .start(start && sel == 1), .k_len(k_len),
    .in_valid(in_valid && sel == 1), .in_ready(ir_b), .a_vec(a_vec[15:0]), .b_vec(b_vec[23:0]),
    .out_valid(ov_b), .out_ready(out_ready && sel == 1), .out_row(row_b),
    .out_row_idx(idx_b), .busy(busy_b), .sat_flag(sat_b));

  systolic_tile_engine #(.ACC_WIDTH(16)) u_c (
    .clk(clk), .reset(reset), .start(start && sel == 2), .k_len(k_len),
    .in_valid(in_valid && sel == 2), .in_ready(ir_c), .a_vec(a_vec), .b_vec(b_vec),
    .out_valid(ov_c), .out_ready(out_ready && sel == 2), .out_row(row_c),
    .out_row_idx(idx_c), .busy(busy_c), .sat_flag(sat_c));

  always_comb begin
    obs_ir = ir_a; obs_ov = ov_a; obs_busy = busy_a; obs_sat = sat_a;
    obs_row = row_a; obs_idx = idx_a;
    if (sel == 1) begin
      obs_ir = ir_b; obs_ov = ov_b; obs_busy = busy_b; obs_sat = sat_b;
      obs_row = {32'd0, row_b}; obs_idx = {1'b0, idx_b};
    end else if (sel == 2) begin
      obs_ir = ir_c; obs_ov = ov_c; obs_busy = busy_c; obs_sat = sat_c;
      for (int j = 0; j < 4; j++) obs_row[j] = {{16{row_c[j*16+15]}}, row_c[j*16 +: 16]};
      obs_idx = idx_c;
    end
  end

  function automatic int nr(); return (sel == 1) ? 2 : 4; endfunction
  function automatic int nc(); return (sel == 1) ? 3 : 4; endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic build_expected(input int k);
    longint acc, hi, lo;
    row_t   e;
    hi = (sel == 2) ? 32767 : 64'sd2147483647;
    lo = (sel == 2) ? -32768 : -64'sd2147483648;
    exp_sat = 1'b0;
    for (int r = 0; r < nr(); r++) begin
      e.idx = 2'(r);
      e.v   = '0;
      for (int c = 0; c < nc(); c++) begin
        acc = 0;
        for (int kk = 0; kk < k; kk++) begin
          acc += longint'(A[kk][r]) * longint'(B[kk][c]);
          if (acc > hi) begin acc = hi; exp_sat = 1'b1; end
          else if (acc < lo) begin acc = lo; exp_sat = 1'b1; end
        end
        e.v[c] = 32'(acc);
      end
      sb.push_back(e);
    end
  endtask

  task automatic set_identity();
    for (int kk = 0; kk < 8; kk++)
      for (int i = 0; i < 4; i++) begin
        A[kk][i] = (i == kk) ? 1 : 0;
        B[kk][i] = 4 * kk + i + 1;
      end
  endtask

  task automatic set_fill(input int av, input int bv);
    for (int kk = 0; kk < 8; kk++)
      for (int i = 0; i < 4; i++) begin A[kk][i] = av; B[kk][i] = bv; end
  endtask

  task automatic drive_beat(input int kk);
    for (int i = 0; i < 4; i++) begin
      a_vec[i*8 +: 8] = 8'(A[kk][i]);
      b_vec[i*8 +: 8] = 8'(B[kk][i]);
    end
  endtask

  // Runs one tile on the selected engine; called at a negedge with the engine idle.
  task automatic run_tile(input int k, input bit bubbles, input bit bp, input bit poke);
    int beat = 0, budget = 0, hs = 0, stall = 0, t_last = 0, t_first = -1;
    build_expected(k);
    start = 1'b1; k_len = 9'(k);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", obs_busy, 1'b1);
    while (beat < k && budget < 200) begin
      in_valid = bubbles ? ((budget % 3) == 0) : 1'b1;
      drive_beat(beat);
      start = poke && (beat == 1);
      if (poke) k_len = '0;
      if (in_valid && obs_ir) begin beat++; t_last = cyc; end
      @(negedge clk);
      budget++;
    end
    in_valid = 1'b0; start = 1'b0;
    check("beats_accepted", beat, k);
    budget = 0;
    while (hs < nr() && budget < 400) begin
      out_ready = 1'b0; start = 1'b0;
      if (obs_ov) begin
        if (t_first < 0) t_first = cyc;
        check("row_idx", obs_idx, sb[0].idx);
        check("row_data", obs_row, sb[0].v);
        if (poke && hs == 1) start = 1'b1;
        if (!bp || stall == 3) begin
          out_ready = 1'b1; void'(sb.pop_front()); hs++; stall = 0;
        end else stall++;
      end
      @(negedge clk);
      budget++;
    end
    out_ready = 1'b0; start = 1'b0;
    check("handshakes", hs, nr());
    if (k > 0 && !bubbles) check("latency", t_first - t_last, nr() + nc() - 1);
    check("out_valid_after_drain", obs_ov, 1'b0);
    check("busy_after_drain", obs_busy, 1'b0);
    check("sat_flag", obs_sat, exp_sat);
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    k_len = '0; a_vec = '0; b_vec = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_busy", obs_busy, 1'b0);
      check("rst_in_ready", obs_ir, 1'b0);
      check("rst_out_valid", obs_ov, 1'b0);
      check("rst_sat", obs_sat, 1'b0);
      check("rst_row", {obs_idx, obs_row}, '0);
    end
    @(negedge clk);
    reset = 1'b0;
    sel = 0;
    @(negedge clk);

    set_identity();
    run_tile(4, 1'b0, 1'b0, 1'b0);

    sel = 1;
    set_fill(0, 0);
    for (int kk = 0; kk < 3; kk++) begin
      A[kk][0] = -5; A[kk][1] = 3;
      B[kk][0] = 4;  B[kk][1] = -3; B[kk][2] = 2;
    end
    run_tile(3, 1'b0, 1'b0, 1'b0);

    sel = 0;
    set_identity();
    run_tile(4, 1'b1, 1'b1, 1'b0);

    sel = 2;
    set_fill(127, 127);
    run_tile(3, 1'b0, 1'b0, 1'b0);
    set_fill(-128, 127);
    run_tile(3, 1'b0, 1'b0, 1'b0);
    set_identity();
    run_tile(4, 1'b0, 1'b0, 1'b0);

    sel = 0;
    set_identity();
    start = 1'b1; k_len = 9'd4;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 10 && beats < 2; c++) begin
      in_valid = 1'b1;
      drive_beat(beats);
      if (obs_ir) beats++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", obs_busy, 1'b0);
    check("abort_in_ready", obs_ir, 1'b0);
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      if (obs_ov) beats++;
      @(negedge clk);
    end
    check("abort_no_output", beats, 0);
    run_tile(4, 1'b0, 1'b0, 1'b0);

    run_tile(4, 1'b0, 1'b0, 1'b1);
    run_tile(0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
